// File: rtl/rename_pkg.sv
// Shared widths and helpers for the N-wide rename stage: selector widths,
// slot popcount and modulo pointer arithmetic.
package rename_pkg;

    localparam int unsigned MAX_W = 4;  // widest dispatch/commit group
    localparam int unsigned CNT_W = 3;  // holds 0..MAX_W

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned cnt,
                                             input int unsigned num);
        return (ptr + cnt) % num;
    endfunction

    function automatic logic wraps(input int unsigned ptr, input int unsigned cnt,
                                   input int unsigned num);
        return (ptr + cnt) >= num;
    endfunction

endpackage

// File: rtl/rrf_ptr_alloc.sv
// RRF allocation and commit pointers with wrap-parity bits, free-entry counter
// and one-cycle flush rollback of the allocation pointer to the committed point.
module rrf_ptr_alloc
    import rename_pkg::*;
#(
    parameter int unsigned RRF_NUM = 64,
    parameter int unsigned RRF_SEL = 6
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic [CNT_W-1:0]   dcnt_i,
    input  logic [CNT_W-1:0]   ccnt_i,
    output logic [RRF_SEL-1:0] rrfptr_o,
    output logic               nextrrfcyc_o,
    output logic [RRF_SEL:0]   freenum_o
);

    localparam int unsigned FREE_W = RRF_SEL + 1;

    logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
    logic [RRF_SEL-1:0] comptr_q, comptr_d;
    logic               rrfcyc_q, rrfcyc_d;
    logic               comcyc_q, comcyc_d;
    logic [RRF_SEL:0]   freenum_q, freenum_d;

    always_comb begin
        comptr_d = RRF_SEL'(wrap_add(32'(comptr_q), 32'(ccnt_i), RRF_NUM));
        comcyc_d = comcyc_q ^ wraps(32'(comptr_q), 32'(ccnt_i), RRF_NUM);
        rrfptr_d = rrfptr_q;
        rrfcyc_d = rrfcyc_q;
        freenum_d = freenum_q;
        if (flush_i) begin
            // Everything speculative is dropped; resume allocation right after
            // the last instruction that has committed, including this cycle's.
            rrfptr_d  = comptr_d;
            rrfcyc_d  = comcyc_d;
            freenum_d = FREE_W'(RRF_NUM);
        end else begin
            rrfptr_d  = RRF_SEL'(wrap_add(32'(rrfptr_q), 32'(dcnt_i), RRF_NUM));
            rrfcyc_d  = rrfcyc_q ^ wraps(32'(rrfptr_q), 32'(dcnt_i), RRF_NUM);
            freenum_d = freenum_q - FREE_W'(dcnt_i) + FREE_W'(ccnt_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rrfptr_q  <= '0;
            comptr_q  <= '0;
            rrfcyc_q  <= 1'b0;
            comcyc_q  <= 1'b0;
            freenum_q <= FREE_W'(RRF_NUM);
        end else begin
            rrfptr_q  <= rrfptr_d;
            comptr_q  <= comptr_d;
            rrfcyc_q  <= rrfcyc_d;
            comcyc_q  <= comcyc_d;
            freenum_q <= freenum_d;
        end
    end

    assign rrfptr_o     = rrfptr_q;
    assign nextrrfcyc_o = rrfcyc_q;
    assign freenum_o    = freenum_q;

    // Cannot retire more entries than are currently in flight.
    commit_within_inflight : assert property (@(posedge clk_i) disable iff (reset_i)
        32'(ccnt_i) <= RRF_NUM - 32'(freenum_q));

endmodule

// File: rtl/rename_table_n.sv
// N-wide rename stage: architectural busy/tag table, consecutive RRF tag
// allocation, intra-group RAW/WAW resolution and tag-checked commit release.
module rename_table_n
    import rename_pkg::*;
#(
    parameter int unsigned DISPATCH_W = 2,
    parameter int unsigned COMMIT_W   = 2,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned RRF_NUM    = 64,
    parameter int unsigned REG_SEL    = sel_width(REG_NUM),
    parameter int unsigned RRF_SEL    = sel_width(RRF_NUM)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           flush_i,
    input  logic                           stall_dp_i,
    input  logic [DISPATCH_W-1:0]          dp_valid_i,
    input  logic [DISPATCH_W*REG_SEL-1:0]  rs1_i,
    input  logic [DISPATCH_W*REG_SEL-1:0]  rs2_i,
    input  logic [DISPATCH_W*REG_SEL-1:0]  rd_i,
    input  logic [DISPATCH_W-1:0]          rd_en_i,
    output logic [DISPATCH_W-1:0]          rs1_busy_o,
    output logic [DISPATCH_W-1:0]          rs2_busy_o,
    output logic [DISPATCH_W*RRF_SEL-1:0]  rs1_tag_o,
    output logic [DISPATCH_W*RRF_SEL-1:0]  rs2_tag_o,
    output logic [DISPATCH_W*RRF_SEL-1:0]  rd_tag_o,
    output logic                           allocatable_o,
    output logic [RRF_SEL:0]               freenum_o,
    output logic [RRF_SEL-1:0]             rrfptr_o,
    output logic                           nextrrfcyc_o,
    input  logic [COMMIT_W-1:0]            com_valid_i,
    input  logic [COMMIT_W-1:0]            com_we_i,
    input  logic [COMMIT_W*REG_SEL-1:0]    com_rd_i,
    input  logic [COMMIT_W*RRF_SEL-1:0]    com_tag_i
);

    localparam int unsigned FREE_W = RRF_SEL + 1;

    logic [REG_NUM-1:0]                 busy_q, busy_d;
    logic [REG_NUM-1:0][RRF_SEL-1:0]    tag_q, tag_d;

    logic [DISPATCH_W-1:0][REG_SEL-1:0] rs1_s, rs2_s, rd_s;
    logic [DISPATCH_W-1:0][RRF_SEL-1:0] rd_tag, rs1_tag, rs2_tag;
    logic [COMMIT_W-1:0][REG_SEL-1:0]   com_rd_s;
    logic [COMMIT_W-1:0][RRF_SEL-1:0]   com_tag_s;

    logic [CNT_W-1:0] dp_cnt, dcnt, ccnt;
    logic             fire;

    assign rs1_s     = rs1_i;
    assign rs2_s     = rs2_i;
    assign rd_s      = rd_i;
    assign com_rd_s  = com_rd_i;
    assign com_tag_s = com_tag_i;

    assign dp_cnt        = popcount(MAX_W'(dp_valid_i));
    assign ccnt          = popcount(MAX_W'(com_valid_i));
    assign allocatable_o = freenum_o >= FREE_W'(dp_cnt);
    assign fire          = |dp_valid_i & ~stall_dp_i & allocatable_o & ~flush_i;
    assign dcnt          = fire ? dp_cnt : '0;

    // Tags double as ROB indices, so every slot gets one whether or not it writes rd.
    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            rd_tag[k] = rrfptr_o + RRF_SEL'(k);
        end
    end

    always_comb begin
        rs1_busy_o = '0;
        rs2_busy_o = '0;
        rs1_tag    = '0;
        rs2_tag    = '0;
        for (int k = 0; k < DISPATCH_W; k++) begin
            rs1_busy_o[k] = busy_q[rs1_s[k]];
            rs1_tag[k]    = tag_q[rs1_s[k]];
            rs2_busy_o[k] = busy_q[rs2_s[k]];
            rs2_tag[k]    = tag_q[rs2_s[k]];
            // Ascending scan: the youngest older writer is the last to override.
            for (int j = 0; j < k; j++) begin
                if (dp_valid_i[j] && rd_en_i[j] && rd_s[j] != '0) begin
                    if (rd_s[j] == rs1_s[k]) begin
                        rs1_busy_o[k] = 1'b1;
                        rs1_tag[k]    = rd_tag[j];
                    end
                    if (rd_s[j] == rs2_s[k]) begin
                        rs2_busy_o[k] = 1'b1;
                        rs2_tag[k]    = rd_tag[j];
                    end
                end
            end
            if (rs1_s[k] == '0) begin
                rs1_busy_o[k] = 1'b0;
                rs1_tag[k]    = '0;
            end
            if (rs2_s[k] == '0) begin
                rs2_busy_o[k] = 1'b0;
                rs2_tag[k]    = '0;
            end
        end
    end

    assign rs1_tag_o = rs1_tag;
    assign rs2_tag_o = rs2_tag;
    assign rd_tag_o  = rd_tag;

    always_comb begin
        busy_d = busy_q;
        tag_d  = tag_q;
        // A stale tag means rd was renamed again; the newer producer still owns it.
        for (int c = 0; c < COMMIT_W; c++) begin
            if (com_valid_i[c] && com_we_i[c] && tag_q[com_rd_s[c]] == com_tag_s[c]) begin
                busy_d[com_rd_s[c]] = 1'b0;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end else if (fire) begin
            for (int k = 0; k < DISPATCH_W; k++) begin
                if (dp_valid_i[k] && rd_en_i[k] && rd_s[k] != '0) begin
                    busy_d[rd_s[k]] = 1'b1;
                    tag_d[rd_s[k]]  = rd_tag[k];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
            tag_q  <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    rrf_ptr_alloc #(
        .RRF_NUM (RRF_NUM),
        .RRF_SEL (RRF_SEL)
    ) u_rrf_ptr_alloc (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .flush_i      (flush_i),
        .dcnt_i       (dcnt),
        .ccnt_i       (ccnt),
        .rrfptr_o     (rrfptr_o),
        .nextrrfcyc_o (nextrrfcyc_o),
        .freenum_o    (freenum_o)
    );

    dp_valid_contiguous : assert property (@(posedge clk_i) disable iff (reset_i)
        (dp_valid_i & (dp_valid_i + DISPATCH_W'(1))) == '0);
    com_valid_contiguous : assert property (@(posedge clk_i) disable iff (reset_i)
        (com_valid_i & (com_valid_i + COMMIT_W'(1))) == '0);

endmodule
